// File: rtl/in_shake_multi_if.sv
// Bundle of raw discrete inputs and their debounced level/edge outputs.
// The board side drives in_i; the debouncer drives everything else.
interface in_shake_multi_if #(
  parameter int CH = 8
);
  logic [CH-1:0] in_i;
  logic [CH-1:0] in_o;
  logic [CH-1:0] rise_o;
  logic [CH-1:0] fall_o;
  logic          chg_o;

  modport master (output in_i, input in_o, rise_o, fall_o, chg_o);
  modport slave  (input in_i, output in_o, rise_o, fall_o, chg_o);
endinterface

// File: rtl/in_shake_multi.sv
// Multi-channel discrete input debouncer: 2-FF sync, symmetric consecutive-sample
// filter per channel, shared sample prescaler, registered level and edge pulses.
module in_shake_multi #(
  parameter int   CH    = 8,
  parameter int   SHAKE = 50,
  parameter int   DIV   = 1,
  parameter logic INIT  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  in_shake_multi_if.slave bus
);

  localparam int             CW      = $clog2(SHAKE + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(SHAKE - 1);

  logic [CH-1:0] s1, s2;
  logic [CH-1:0] lvl, lvl_nxt;
  logic [CH-1:0] rise, rise_nxt;
  logic [CH-1:0] fall, fall_nxt;
  logic          chg, chg_nxt;
  logic [CW-1:0] cnt     [CH];
  logic [CW-1:0] cnt_nxt [CH];
  logic          tick;

  // One tick every DIV clocks; with DIV=1 every clock samples and no counter exists.
  generate
    if (DIV == 1) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      localparam int            DW      = $clog2(DIV);
      localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
      logic [DW-1:0] div_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          div_cnt <= '0;
        end else if (div_cnt == DIV_MAX) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      assign tick = (div_cnt == DIV_MAX);
    end
  endgenerate

  // Any sample agreeing with the current level restarts the count, tick or not,
  // so a glitch never accumulates across separate disturbances.
  always_comb begin
    lvl_nxt  = lvl;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int n = 0; n < CH; n++) begin
      cnt_nxt[n] = cnt[n];
      if (s2[n] == lvl[n]) begin
        cnt_nxt[n] = '0;
      end else if (tick) begin
        if (cnt[n] == CNT_MAX) begin
          lvl_nxt[n]  = s2[n];
          cnt_nxt[n]  = '0;
          rise_nxt[n] = s2[n];
          fall_nxt[n] = ~s2[n];
        end else begin
          cnt_nxt[n] = cnt[n] + 1'b1;
        end
      end
    end
    chg_nxt = |(rise_nxt | fall_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= {CH{INIT}};
      s2   <= {CH{INIT}};
      lvl  <= {CH{INIT}};
      rise <= '0;
      fall <= '0;
      chg  <= 1'b0;
      for (int n = 0; n < CH; n++) begin
        cnt[n] <= '0;
      end
    end else begin
      s1   <= bus.in_i;
      s2   <= s1;
      lvl  <= lvl_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
      chg  <= chg_nxt;
      for (int n = 0; n < CH; n++) begin
        cnt[n] <= cnt_nxt[n];
      end
    end
  end

  assign bus.in_o   = lvl;
  assign bus.rise_o = rise;
  assign bus.fall_o = fall;
  assign bus.chg_o  = chg;

endmodule
